// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg: shared mode encoding and period helpers for the sequence counter
package seq_counter_pkg;
  typedef enum logic [1:0] {RING, JOHNSON, BINARY, TABLE} mode_e;
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    return (a >= b && a >= c) ? a : (b >= c ? b : c);
  endfunction
  function automatic int unsigned period_of(mode_e m, int unsigned len, int unsigned width);
    return m == RING ? width : m == JOHNSON ? 2 * width : m == BINARY ? (32'd1 << width) : len;
  endfunction
endpackage

// File: rtl/seq_pattern_decode.sv
// seq_pattern_decode: combinational map from (mode, position, table entry) to output pattern
module seq_pattern_decode
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int P_W = 4
) (
  input  mode_e            mode,
  input  logic [P_W-1:0]   p,
  input  logic [WIDTH-1:0] tbl_rd,
  output logic [WIDTH-1:0] count_out
);
  logic [WIDTH-1:0] ring, john;
  always_comb begin
    ring = WIDTH'(1) << p;
    // Johnson fills ones from the bottom, then shifts them out the top
    john = (p <= P_W'(WIDTH)) ? ring - WIDTH'(1) : {WIDTH{1'b1}} << (p - P_W'(WIDTH));
    count_out = mode == RING ? ring : mode == JOHNSON ? john : mode == BINARY ? p[WIDTH-1:0] : tbl_rd;
  end
endmodule

// File: rtl/seq_counter_param.sv
// seq_counter_param: programmable ring/Johnson/binary/table sequence counter
module seq_counter_param
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int P_W = int'(max3(WIDTH, IDX_W, $clog2(2 * WIDTH)))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             restart,
  input  logic [1:0]       mode_in,
  input  logic [IDX_W:0]   tbl_len,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count_out,
  output logic [P_W-1:0]   step_idx,
  output logic             wrap
);
  logic [P_W-1:0] p, p_nxt;
  mode_e mode_q;
  logic [IDX_W:0] len_q, len_c;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [P_W:0] per, last;
  logic wrapped;
  always_comb begin
    per = (P_W + 1)'(period_of(mode_q, 32'(len_q), WIDTH));
    last = per - 1'b1;
    wrapped = dir ? (p == '0) : ({1'b0, p} == last);
    p_nxt = dir ? (wrapped ? last[P_W-1:0] : p - 1'b1) : (wrapped ? '0 : p + 1'b1);
    len_c = (tbl_len == '0 || tbl_len > (IDX_W + 1)'(DEPTH)) ? (IDX_W + 1)'(DEPTH) : tbl_len;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p <= '0;
      mode_q <= RING;
      len_q <= (IDX_W + 1)'(DEPTH);
      wrap <= 1'b0;
    end else if (restart) begin
      p <= '0;
      mode_q <= mode_e'(mode_in);
      len_q <= len_c;
      wrap <= 1'b0;
    end else begin
      p <= en ? p_nxt : p;
      wrap <= en && wrapped;
    end
  // Table writes are independent of stepping; a step never reads the table
  always_ff @(posedge clk or negedge reset)
    if (!reset) tbl <= '{default: '0};
    else if (wr_en) tbl[wr_addr] <= wr_data;
  seq_pattern_decode #(.WIDTH(WIDTH), .P_W(P_W)) u_dec (
    .mode(mode_q),
    .p(p),
    .tbl_rd(tbl[p[IDX_W-1:0]]),
    .count_out(count_out)
  );
  assign step_idx = p;
endmodule

// File: tb/tb_seq_counter_param.sv
// tb_seq_counter_param: directed checks of seq_counter_param at WIDTH=4, DEPTH=8
module tb_seq_counter_param;
  logic clk = 1'b0, reset, en, dir, restart, wr_en;
  logic [1:0] mode_in;
  logic [3:0] tbl_len;
  logic [2:0] wr_addr;
  logic [3:0] wr_data, count_out, step_idx;
  logic wrap;
  int tests = 0, fails = 0;
  logic [3:0] ring_x [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] john_x [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] tbl_x [3] = '{4'h9, 4'h5, 4'h3};

  seq_counter_param #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .restart(restart),
    .mode_in(mode_in), .tbl_len(tbl_len), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count_out(count_out), .step_idx(step_idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rst_mode(input logic [1:0] m, input logic [3:0] len);
    restart = 1'b1; mode_in = m; tbl_len = len;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; restart = 1'b0; mode_in = 2'd0;
    tbl_len = 4'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    tick(); tick();
    check("rst_count", count_out, 4'h1);
    check("rst_idx", step_idx, 4'd0);
    check("rst_wrap", wrap, 1'b0);
    reset = 1'b1; en = 1'b1;
    tick(); tick();
    check("ring_p2", count_out, 4'h4);
    #2 reset = 1'b0;
    #1 check("async_count", count_out, 4'h1);
    check("async_idx", step_idx, 4'd0);
    check("async_wrap", wrap, 1'b0);
    tick(); tick();
    check("rst_hold_count", count_out, 4'h1);
    check("rst_hold_idx", step_idx, 4'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ring_fwd%0d", i), count_out, ring_x[i]);
      check($sformatf("ring_wrap%0d", i), wrap, i == 3);
    end
    en = 1'b0;
    rst_mode(2'd1, 4'd0);
    check("john_start", count_out, 4'h0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("john_fwd%0d", i), count_out, john_x[i]);
      check($sformatf("john_wrap%0d", i), wrap, i == 7);
    end
    dir = 1'b1;
    tick();
    check("john_back", count_out, 4'h8);
    check("john_back_wrap", wrap, 1'b1);
    en = 1'b0; dir = 1'b0;
    wr(3'd0, 4'h3); wr(3'd1, 4'h9); wr(3'd2, 4'h5);
    rst_mode(2'd3, 4'd3);
    check("tbl_start", count_out, 4'h3);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tbl_step%0d", i), count_out, tbl_x[i]);
      check($sformatf("tbl_wrap%0d", i), wrap, i == 2);
    end
    en = 1'b0;
    wr(3'd0, 4'hF);
    check("tbl_live_write", count_out, 4'hF);
    rst_mode(2'd2, 4'd0);
    check("bin_start", count_out, 4'h0);
    en = 1'b1; dir = 1'b1;
    tick();
    check("bin_back0", count_out, 4'hF);
    check("bin_back0_wrap", wrap, 1'b1);
    tick();
    check("bin_back1", count_out, 4'hE);
    check("bin_back1_wrap", wrap, 1'b0);
    check("bin_back1_idx", step_idx, 4'd14);
    rst_mode(2'd2, 4'd0);
    check("prio_idx", step_idx, 4'd0);
    check("prio_wrap", wrap, 1'b0);
    dir = 1'b0; mode_in = 2'd0;
    tick(); tick();
    check("mode_ignored", count_out, 4'h2);
    en = 1'b0;
    rst_mode(2'd3, 4'd0);
    en = 1'b1;
    repeat (7) tick();
    check("len0_idx7", step_idx, 4'd7);
    check("len0_nowrap", wrap, 1'b0);
    tick();
    check("len0_idx0", step_idx, 4'd0);
    check("len0_wrap", wrap, 1'b1);
    check("len0_count", count_out, 4'hF);
    en = 1'b0;
    rst_mode(2'd3, 4'd1);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("len1_wrap%0d", i), wrap, 1'b1);
      check($sformatf("len1_count%0d", i), count_out, 4'hF);
      check($sformatf("len1_idx%0d", i), step_idx, 4'd0);
    end
    en = 1'b0;
    tick();
    check("len1_idle_wrap", wrap, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_counter_param.md
Name:
seq_counter_param

Overview:
- Parametrised, run-time-programmable sequence counter. It generalises the fixed 4-step one-hot sequencer into four modes: ring, Johnson, binary, and a user-loaded sequence table.
- Adds bidirectional stepping, count enable, synchronous restart with mode/length capture, a programmable sequence table, and a wrap pulse.
- Sits in the lab-board datapath, driving LED/7-seg patterns and sequencing strobes.

Parameters:
- WIDTH, 4: output pattern width in bits (2..16).
- DEPTH, 8: number of sequence-table entries (2..64, power of two).
- IDX_W, $clog2(DEPTH): table address width. Derived; do not override.
- P_W, max(WIDTH, IDX_W, $clog2(2*WIDTH)): position register width. Derived.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- en, in, 1: advance one step this cycle.
- dir, in, 1: 0 = forward (p+1), 1 = backward (p-1).
- restart, in, 1: synchronous restart; captures mode_in and tbl_len.
- mode_in, in, 2: 0 RING, 1 JOHNSON, 2 BINARY, 3 TABLE.
- tbl_len, in, IDX_W+1: table sequence length. 0 or >DEPTH means DEPTH.
- wr_en, in, 1: table write strobe.
- wr_addr, in, IDX_W: table write address.
- wr_data, in, WIDTH: table write data.
- count_out, out, WIDTH: current pattern.
- step_idx, out, P_W: current position p.
- wrap, out, 1: one-cycle pulse, high while count_out shows the wrapped-to value.

Behaviour:
- Registered state: p, mode_q, len_q, wrap, tbl[DEPTH].
- count_out is a combinational decode of (mode_q, p, tbl[p]). There is no extra register stage, so count_out changes on the same edge as p.
- Reset asserted (reset=0), immediately and asynchronously:
  - p=0, mode_q=RING, len_q=DEPTH, wrap=0, all tbl entries=0.
  - Therefore count_out=0…01 and step_idx=0.
  - Holds while reset=0; stepping resumes on the first edge after release.
- Period by mode_q: RING=WIDTH, JOHNSON=2*WIDTH, BINARY=2^WIDTH, TABLE=len_q. Compute in P_W+1 bits.
- Decode by mode_q:
  - RING: 1<<p.
  - JOHNSON: p≤WIDTH gives (1<<p)-1; p>WIDTH gives all-ones<<(p-WIDTH). Sequence for W=4: 0000,0001,0011,0111,1111,1110,1100,1000.
  - BINARY: p[WIDTH-1:0].
  - TABLE: tbl[p].
- Per rising edge, priority highest first:
  1. restart: p=0; mode_q=mode_in; len_q=clamp(tbl_len); wrap=0.
  2. en, dir=0: p=(p==period-1)?0:p+1; wrap=1 iff p wrapped.
  3. en, dir=1: p=(p==0)?period-1:p-1; wrap=1 iff p wrapped.
  4. Otherwise: p holds; wrap=0.
- mode_in and tbl_len changes without restart are ignored.
- Table writes:
  - wr_en writes tbl[wr_addr]=wr_data every edge, independent of restart/en, in any mode.
  - A write to the entry currently selected (TABLE mode) appears on count_out the following cycle.
  - Same-edge write plus step: the step uses the old table contents. Only the read of the new p reflects the written data.
- len_q=1 in TABLE mode: every enabled step wraps, so p stays 0 and wrap=1 on each en cycle.
- wrap is registered, never combinational. With continuous en it pulses exactly once per period.

Decomposition:
- Package seq_counter_pkg:
  - typedef enum logic [1:0] mode_e {RING, JOHNSON, BINARY, TABLE}.
  - Function for the period calculation.
- Sub-module seq_pattern_decode: purely combinational decode of (mode_q, p, tbl_rd) → count_out. Parameters WIDTH, P_W.
- Top level holds the position FSM, table RAM (flops) and wrap logic.

Test Plan (WIDTH=4, DEPTH=8):
1. Reset: run RING to p=2, drive reset=0 between edges → count_out=0001, step_idx=0, wrap=0 immediately, without waiting for clk. Hold en=1 during reset → no stepping.
2. RING forward: en=1 for 4 cycles → count_out 0010, 0100, 1000, 0001. wrap=1 only in the 4th cycle.
3. JOHNSON: restart with mode_in=1, then en=1 dir=0 for 8 cycles → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 (wrap on last). Then dir=1 for one step → 1000 with wrap=1.
4. TABLE: write tbl[0..2]=3, 9, 5; restart with mode_in=3, tbl_len=3 → count_out=0011. en for 3 steps → 1001, 0101, 0011 (wrap). Write tbl[0]=F while p=0 → count_out=1111 next cycle.
5. BINARY backward: restart mode_in=2, en=1 dir=1 → 1111 with wrap=1, then 1110.
6. Priority and clamps:
   - restart and en in the same cycle → p=0, wrap=0.
   - Change mode_in without restart → pattern unchanged.
   - tbl_len=0 → period 8.
   - tbl_len=1 → wrap every en cycle, count_out constant.
